// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared mode type and parameter legality check for sync_fifo_flagged.
package sync_fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic bit params_ok(int depth, int size_bits, int af, int ae, int fwft);
    return depth >= 4 && (depth & (depth - 1)) == 0 && size_bits == $clog2(depth) &&
           af >= 1 && af <= depth - 1 && ae >= 0 && ae <= depth - 2 && (fwft == 0 || fwft == 1);
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: depth x width simple dual-port RAM, synchronous write and registered read.
module sync_fifo_ram #(
  parameter int width     = 16,
  parameter int depth     = 16,
  parameter int addr_bits = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_wa,
  input  logic [width-1:0]     i_wd,
  input  logic                 i_re,
  input  logic [addr_bits-1:0] i_ra,
  output logic [width-1:0]     o_rd
);
  logic [width-1:0] r_mem [depth];
  always_ff @(posedge clk) if (i_we) r_mem[i_wa] <= i_wd;
  // Only the read register is reset; array contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (rst) o_rd <= '0;
    else if (i_re) o_rd <= r_mem[i_ra];
  end
endmodule

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with optional first-word-fall-through output,
// programmable almost-full/almost-empty, occupancy count and sticky error flags.
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int width     = 16,
  parameter int depth     = 16,
  parameter int size_bits = 4,
  parameter int af_thresh = 14,
  parameter int ae_thresh = 2,
  parameter int fwft      = 0
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 fifo_write,
  input  logic                 fifo_read,
  input  logic [width-1:0]     fifo_data_in,
  input  logic                 fifo_clr_err,
  output logic [width-1:0]     fifo_data_out,
  output logic                 fifo_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 fifo_almost_full,
  output logic                 fifo_almost_empty,
  output logic [size_bits:0]   fifo_count,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow
);
  localparam fifo_mode_e MODE = (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [size_bits:0] DEPTH_C = depth[size_bits:0];
  localparam logic [size_bits:0] AF_C = af_thresh[size_bits:0];
  localparam logic [size_bits:0] AE_C = ae_thresh[size_bits:0];
  localparam logic [size_bits:0] CNT_ONE = 1;
  localparam logic [size_bits-1:0] PTR_ONE = 1;

  if (!params_ok(depth, size_bits, af_thresh, ae_thresh, fwft)) begin : g_bad_params
    $error("sync_fifo_flagged: illegal depth/size_bits/threshold/fwft parameters");
  end

  logic [size_bits-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt, w_ram_ra;
  logic [size_bits:0]   r_count, w_count_nxt;
  logic                 r_full, r_empty, r_af, r_ae, r_ovf, r_unf, r_valid, r_byp;
  logic                 w_wr_en, w_rd_en, w_ram_re;
  logic [width-1:0]     r_byp_data, w_ram_q;

  always_comb begin
    w_wr_en     = fifo_write && !r_full;
    w_rd_en     = fifo_read && !r_empty;
    w_rd_nxt    = w_rd_en ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    w_count_nxt = (w_wr_en && !w_rd_en) ? r_count + CNT_ONE :
                  (w_rd_en && !w_wr_en) ? r_count - CNT_ONE : r_count;
    // FWFT prefetches the next head every cycle; standard mode reads only on a pop.
    w_ram_re    = (MODE == FIFO_FWFT) ? 1'b1 : w_rd_en;
    w_ram_ra    = (MODE == FIFO_FWFT) ? w_rd_nxt : r_rd_ptr;
  end

  sync_fifo_ram #(.width(width), .depth(depth), .addr_bits(size_bits)) u_ram (
    .clk  (clk),
    .rst  (rst_),
    .i_we (w_wr_en),
    .i_wa (r_wr_ptr),
    .i_wd (fifo_data_in),
    .i_re (w_ram_re),
    .i_ra (w_ram_ra),
    .o_rd (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_valid    <= 1'b0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_count_nxt;
      r_full     <= w_count_nxt == DEPTH_C;
      r_empty    <= w_count_nxt == '0;
      r_af       <= w_count_nxt >= AF_C;
      r_ae       <= w_count_nxt <= AE_C;
      r_ovf      <= (fifo_write && r_full) || (r_ovf && !fifo_clr_err);
      r_unf      <= (fifo_read && r_empty) || (r_unf && !fifo_clr_err);
      r_valid    <= w_rd_en;
      // A write landing on the slot being prefetched is the new head; RAM would return stale data.
      r_byp      <= w_wr_en && (r_wr_ptr == w_rd_nxt);
      r_byp_data <= fifo_data_in;
    end
  end

  always_comb begin
    fifo_data_out     = (MODE == FIFO_FWFT && r_byp) ? r_byp_data : w_ram_q;
    fifo_valid        = (MODE == FIFO_FWFT) ? !r_empty : r_valid;
    fifo_full         = r_full;
    fifo_empty        = r_empty;
    fifo_almost_full  = r_af;
    fifo_almost_empty = r_ae;
    fifo_count        = r_count;
    fifo_overflow     = r_ovf;
    fifo_underflow    = r_unf;
  end
endmodule
